// File: rtl/axi_regfile_v2.sv
// axi_regfile_v2: AXI4-Lite slave exposing NUM_REGS 32-bit registers.
// RW registers are written over AXI and driven out on slv_reg.
// RO registers (RO_MASK bit set) return slv_read on reads and ignore writes.
// AW and W are buffered independently; a write commits on the edge after both are held.
// Optional build macro: AXI_REGFILE_SLVERR_EN. When defined, out-of-range accesses
// and writes to RO registers answer SLVERR; otherwise every response is OKAY.
module axi_regfile_v2 #(
    parameter int                         NUM_REGS           = 16,
    parameter int                         C_S_AXI_ADDR_WIDTH = 8,
    parameter logic [NUM_REGS-1:0]        RO_MASK            = '0,
    parameter logic [NUM_REGS*32-1:0]     RESET_VAL          = '0
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]        slv_reg,
    input  logic [NUM_REGS*32-1:0]        slv_read,
    output logic [NUM_REGS-1:0]           wr_strobe
);
    localparam int         IW          = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                ready_en;
    logic                aw_held;
    logic [IW-1:0]       aw_idx;
    logic                w_held;
    logic [31:0]         w_data;
    logic [3:0]          w_strb;
    logic                bvalid;
    logic [1:0]          bresp;
    logic                rvalid;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic [NUM_REGS-1:0] strobe_q;
    logic [31:0]         regs [NUM_REGS];

    logic [IW-1:0]       ar_idx;
    logic [NUM_REGS-1:0] wr_hit;
    logic [NUM_REGS-1:0] wr_rw_hit;
    logic [NUM_REGS-1:0] rd_hit;
    logic [31:0]         rd_value;
    logic [1:0]          wr_resp;
    logic [1:0]          rd_resp;
    logic                aw_fire;
    logic                w_fire;
    logic                ar_fire;
    logic                commit;
    logic                unused_ok;

    assign ar_idx        = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign S_AXI_AWREADY = ready_en & ~aw_held & ~bvalid;
    assign S_AXI_WREADY  = ready_en & ~w_held & ~bvalid;
    assign S_AXI_ARREADY = ready_en & ~rvalid;
    assign aw_fire       = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_fire        = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_fire       = S_AXI_ARVALID & S_AXI_ARREADY;
    assign commit        = aw_held & w_held;
    assign wr_rw_hit     = wr_hit & ~RO_MASK;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = rresp;
    assign wr_strobe     = strobe_q;
    assign unused_ok     = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                             S_AXI_ARADDR[1:0], rd_hit};

`ifdef AXI_REGFILE_SLVERR_EN
    assign wr_resp = (|wr_rw_hit) ? RESP_OKAY : RESP_SLVERR;
    assign rd_resp = (|rd_hit) ? RESP_OKAY : RESP_SLVERR;
`else
    assign wr_resp = RESP_OKAY;
    assign rd_resp = RESP_OKAY;
`endif

    // Decode buffered write index and live read index; an index matching no register is out-of-range
    always_comb begin
        wr_hit   = '0;
        rd_hit   = '0;
        rd_value = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (aw_idx == IW'(i)) begin
                wr_hit[i] = 1'b1;
            end
            if (ar_idx == IW'(i)) begin
                rd_hit[i] = 1'b1;
                rd_value  = RO_MASK[i] ? slv_read[i*32 +: 32] : regs[i];
            end
        end
    end

    // Flatten the register array onto the user-logic bus
    always_comb begin
        slv_reg = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            slv_reg[i*32 +: 32] = regs[i];
        end
    end

    // Write channel: independent AW/W buffers, commit when both held, B held until BREADY
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            ready_en <= 1'b0;
            aw_held  <= 1'b0;
            aw_idx   <= '0;
            w_held   <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            strobe_q <= '0;
        end else begin
            ready_en <= 1'b1;
            strobe_q <= '0;
            if (aw_fire) begin
                aw_held <= 1'b1;
                aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_fire) begin
                w_held <= 1'b1;
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid   <= 1'b1;
                bresp    <= wr_resp;
                strobe_q <= wr_rw_hit;
            end else if (bvalid && S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Register storage: byte-enabled update of in-range RW registers on commit
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL[i*32 +: 32];
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit && wr_rw_hit[i]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_strb[b]) begin
                            regs[i][b*8 +: 8] <= w_data[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read channel: capture data one edge after AR accept, hold until RREADY
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else begin
            if (ar_fire) begin
                rvalid <= 1'b1;
                rdata  <= rd_value;
                rresp  <= rd_resp;
            end else if (rvalid && S_AXI_RREADY) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule
